// File: rtl/display_mux.sv
// Time-multiplexed common-anode 7-segment scanner with dead cycle, blanking and decimal point.
// Optional PWM brightness is compiled in when DISPLAY_DIM_EN is defined.
module display_mux #(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned DIM_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7*N_DIGITS-1:0] disp,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blank,
  input  logic [DIM_W-1:0]      bright,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic                  frame_tick
);

  localparam int unsigned PcntW = $clog2(PRESCALE);
  localparam int unsigned IdxW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PcntW-1:0] PcntLast = PcntW'(PRESCALE - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(N_DIGITS - 1);

  logic [PcntW-1:0]    pcnt_q, pcnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_n_q, dp_n_d;
  logic                blank_q, blank_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                frame_tick_q, frame_tick_d;

  logic                slot_end;
  logic                slot_start;
  logic                pwm_on;
  logic [6:0]          cur_seg;
  logic                cur_dp;
  logic                cur_blank;
  logic [N_DIGITS-1:0] an_lit;

  assign slot_end   = (pcnt_q == PcntLast);
  assign slot_start = (pcnt_q == '0);

`ifdef DISPLAY_DIM_EN
  logic [DIM_W-1:0] wcnt_q;
  logic             pwm_on_q;

  // Compare is registered so the anode register sees a flop, not a comparator chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q   <= '0;
      pwm_on_q <= 1'b0;
    end else begin
      wcnt_q   <= wcnt_q + 1'b1;
      pwm_on_q <= (wcnt_q <= bright);
    end
  end

  assign pwm_on = pwm_on_q;
`else
  logic unused_bright;
  assign unused_bright = ^bright;
  assign pwm_on        = 1'b1;
`endif

  // Per-digit selection driven by the current scan index.
  always_comb begin
    cur_seg   = 7'h7F;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    an_lit    = '1;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IdxW'(k)) begin
        cur_seg   = disp[7*k +: 7];
        cur_dp    = dp[k];
        cur_blank = blank[k];
        an_lit[k] = 1'b0;
      end
    end
  end

  always_comb begin
    pcnt_d       = slot_end ? '0 : pcnt_q + 1'b1;
    idx_d        = idx_q;
    seg_d        = seg_q;
    dp_n_d       = dp_n_q;
    blank_d      = blank_q;
    an_d         = '1;
    frame_tick_d = slot_end && (idx_q == IdxLast);

    if (slot_end) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end

    if (slot_start) begin
      // Dead cycle: anodes off while the new pattern is loaded and held for the slot.
      seg_d   = cur_seg;
      dp_n_d  = ~cur_dp;
      blank_d = cur_blank;
    end else if (!blank_q && pwm_on) begin
      an_d = an_lit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      seg_q        <= 7'h7F;
      dp_n_q       <= 1'b1;
      blank_q      <= 1'b1;
      an_q         <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      blank_q      <= blank_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: doc/display_mux.md
# display_mux

Parametrised, time-multiplexed driver for common-anode 7-segment displays with N digits. It scans N digit patterns onto a shared segment bus at a programmable refresh rate, with per-digit decimal point and blanking, one dead cycle between digits to suppress ghosting, and optional PWM brightness control. It sits between the value-to-segment decoders and the board's `an`/`seg` pins, and replaces the fixed 4-digit, clock-rate scanner.

## Interface
Parameters:
- `N_DIGITS`, 4: number of digits scanned; legal range 1..16.
- `PRESCALE`, 50000: clock cycles per digit slot; legal range 4..2^24.
- `DIM_W`, 4: brightness code width; legal range 1..8.

Ports:
- `clk`  in  1  system clock; all state on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `disp`  in  7*N_DIGITS  segment patterns, active-low; digit k is `disp[7k+6:7k]`, bit order g..a.
- `dp`  in  N_DIGITS  decimal point request per digit, active-high.
- `blank`  in  N_DIGITS  digit k forced dark when set.
- `bright`  in  DIM_W  brightness code.
- `an`  out  N_DIGITS  anode select, active-low, at most one bit low at any time.
- `seg`  out  7  segment drive, active-low.
- `dp_n`  out  1  decimal point drive, active-low.
- `frame_tick`  out  1  one-cycle pulse when a full scan of all digits completes.

## Operation
- Reset values: `an` all ones, `seg` = 7'h7F, `dp_n` = 1, `frame_tick` = 0. Internal prescaler, digit index, and PWM counter are all 0.
- Prescaler `pcnt` counts 0..PRESCALE-1 and wraps. `slot_end` is asserted when `pcnt` = PRESCALE-1.
- Digit index `idx` counts 0..N_DIGITS-1.
  - On `slot_end`, `idx` advances; it wraps N_DIGITS-1 -> 0.
  - With N_DIGITS = 1, `idx` stays 0.
- Slot start (the cycle after `slot_end`, or the first cycle after reset release) is the dead cycle:
  - `an` = all ones.
  - `seg` ← `disp` for the new `idx`.
  - `dp_n` ← ~`dp[idx]`.
  - Inputs are sampled once here and held for the whole slot. Input changes mid-slot are invisible until the next slot.
- Remaining PRESCALE-1 cycles of the slot: `an[idx]` = 0 when the digit is lit (see brightness), otherwise all ones.
- Blanking: if `blank[idx]` was set at sampling, `an` stays all ones for the entire slot. `seg` still loads the pattern, and `idx` still advances. Scan timing never changes.
- `frame_tick` pulses for one cycle on the `slot_end` where `idx` = N_DIGITS-1.
- Reset asserted mid-slot: all outputs return to reset values asynchronously. Scanning restarts at digit 0 with a dead cycle.

## Timing
- Slot length is exactly PRESCALE cycles. Frame length is N_DIGITS*PRESCALE cycles. `frame_tick` period equals the frame length.
- Latency from a `disp`/`dp`/`blank` change to the pins: up to N_DIGITS*PRESCALE+1 cycles, worst case.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Dead cycle: the anode of the old digit is deasserted in the same cycle that `seg` changes. The new anode is asserted exactly 1 cycle later.
- PWM (when enabled):
  - Free-running DIM_W-bit counter `wcnt`, incrementing every cycle and wrapping.
  - Digit lit in a non-dead cycle iff `wcnt` <= `bright`.
  - Duty = (`bright`+1)/2^DIM_W. The all-ones code gives 100%.
  - `bright` is sampled every cycle, not per slot.

## Configuration
- `DISPLAY_DIM_EN` defined:
  - PWM counter and comparison are compiled in.
  - `bright` controls duty as specified above.
- `DISPLAY_DIM_EN` undefined:
  - No PWM logic; `bright` is ignored but the port remains.
  - A non-blanked digit is lit for all PRESCALE-1 non-dead cycles of its slot.

## Test plan
Bench parameters: N_DIGITS=4, PRESCALE=4, DIM_W=2, `DISPLAY_DIM_EN` defined unless noted.
- Reset behaviour: hold `rst_n`=0 for 3 cycles, then release. -> During reset `an`=4'b1111, `seg`=7'h7F, `dp_n`=1. First cycle after release `an`=4'b1111, `seg`=`disp[6:0]`. Next cycle `an`=4'b1110.
- Scan order: `disp`={7'h01,7'h02,7'h04,7'h08}, `bright`=2'b11, no blank. -> `an` sequence per 4-cycle slot is 1111,1110×3 (`seg`=7'h08), then 1111,1101×3 (`seg`=7'h04), …, back to digit 0 after 16 cycles. `frame_tick` is high once per 16 cycles, at the last cycle of digit 3's slot.
- Blanking and decimal point: `blank`=4'b0100, `dp`=4'b0001. -> During digit 2's slot `an`=4'b1111 for all 4 cycles. `dp_n`=0 only during digit 0's slot. Frame period stays 16 cycles.
- Brightness: `bright`=2'b00. -> During non-dead cycles, a digit is lit only when `wcnt`=0, i.e. 1 of 4 cycles over a long run. With `bright`=2'b01, 2 of 4. Never more than one `an` bit is low at once.
- Mid-slot update and reset: change `disp[13:7]` during digit 1's slot. -> `seg` for digit 1 changes only at its next slot. Assert `rst_n`=0 mid-slot. -> Outputs return to reset values in the same cycle, without waiting for a clock edge.
- Dimming compiled out: `DISPLAY_DIM_EN` undefined, `bright`=2'b00. -> Each digit is lit 3 of 4 cycles, identical to the `bright`=2'b11 run with dimming enabled.
